seq_divider: RTL



---
 rtl/seq_divider.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor -> DW-bit quotient, VW-bit remainder.
// Latency: DW clocks from the accepting edge to the done edge; divide-by-zero answers on the accepting edge.
// Backpressure: none queued; start is ignored while busy, results hold until the next done.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                request; sampled only while idle, together with dividend/divisor
//   dividend, divisor    operands
//   busy                 high for the DW cycles of an iteration run
//   done                 one-cycle pulse when quotient/remainder/div_by_zero are updated
//   quotient, remainder  results, held between done pulses
//   div_by_zero          set with done when divisor was 0 (quotient then reads all ones)
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // One extra bit so the counter never wraps inside a division.
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] q_reg;   // dividend shifting out / quotient bits shifting in
    logic [VW-1:0] d_reg;   // latched divisor
    logic [VW:0]   r_reg;   // partial remainder, one guard bit for the trial subtract
    logic [CW-1:0] cnt;

    logic [VW:0]   r_sh;
    logic [VW:0]   trial;
    logic [VW:0]   r_step;
    logic [DW-1:0] q_step;
    logic          last_iter;
    logic          accept;
    logic          accept_zero;

    // One restoring step on {R,Q} shifted left by one. R is always < D, so its
    // top bit is zero and the shifted value still fits in VW+1 bits.
    always_comb begin
        r_sh  = {r_reg[VW-1:0], q_reg[DW-1]};
        trial = r_sh - {1'b0, d_reg};
        if (trial[VW]) begin
            r_step = r_sh;
            q_step = {q_reg[DW-2:0], 1'b0};
        end else begin
            r_step = trial;
            q_step = {q_reg[DW-2:0], 1'b1};
        end
    end

    assign last_iter   = (state == RUN) && (cnt == CW'(DW - 1));
    assign accept      = (state == IDLE) && start && (divisor != '0);
    assign accept_zero = (state == IDLE) && start && (divisor == '0);
    assign busy        = (state == RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = RUN;
            RUN:  if (last_iter) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        r_reg       <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                    end else if (accept_zero) begin
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                        remainder   <= '0;
                    end
                end
                RUN: begin
                    q_reg <= q_step;
                    r_reg <= r_step;
                    cnt   <= cnt + CW'(1);
                    if (last_iter) begin
                        quotient  <= q_step;
                        remainder <= r_step[VW-1:0];
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
